// File: rtl/scalar_wb_pkg.sv
// Shared types and default widths for the scalar register-file write-back unit.
// The optional forwarding path is enabled with the SCALAR_WB_BYPASS_EN macro.
package scalar_wb_pkg;

    localparam int unsigned DEF_REGISTER_SIZE     = 8;
    localparam int unsigned DEF_REGISTER_QUANTITY = 8;
    localparam int unsigned DEF_FIFO_DEPTH        = 4;
    localparam int unsigned DEF_IDX_W             = $clog2(DEF_REGISTER_QUANTITY);

    typedef struct packed {
        logic [DEF_IDX_W-1:0]         idx;
        logic [DEF_REGISTER_SIZE-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    function automatic src_e otherSrc(input src_e s);
        return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/scalar_wb_fifo.sv
// Synchronous FIFO of write-back requests; full/empty use an extra pointer MSB.
module scalar_wb_fifo
    import scalar_wb_pkg::*;
#(
    parameter type         T     = wb_req_t,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     pushData,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    T            mem [DEPTH];
    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push && !full) wrPtr <= wrPtr + PTR_ONE;
            if (pop && !empty) rdPtr <= rdPtr + PTR_ONE;
        end
    end

    // Storage is left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && push && !full) mem[wrPtr[AW-1:0]] <= pushData;
    end

    always_comb begin
        empty = (wrPtr == rdPtr);
        full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
        head  = mem[rdPtr[AW-1:0]];
    end

endmodule

// File: rtl/scalar_writeback_unit.sv
// Scalar register-file write side: ALU/mem FIFOs, round-robin retire, pending-write tracking.
// Define SCALAR_WB_BYPASS_EN to add same-cycle forwarding ports rs1/rs2 -> fwd1/fwd2.
module scalar_writeback_unit
    import scalar_wb_pkg::*;
#(
    parameter int unsigned registerSize     = DEF_REGISTER_SIZE,
    parameter int unsigned registerQuantity = DEF_REGISTER_QUANTITY,
    parameter int unsigned FIFO_DEPTH       = DEF_FIFO_DEPTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                alu_valid,
    output logic                                alu_ready,
    input  logic [$clog2(registerQuantity)-1:0] alu_idx,
    input  logic [registerSize-1:0]             alu_data,
    input  logic                                mem_valid,
    output logic                                mem_ready,
    input  logic [$clog2(registerQuantity)-1:0] mem_idx,
    input  logic [registerSize-1:0]             mem_data,
`ifdef SCALAR_WB_BYPASS_EN
    input  logic [$clog2(registerQuantity)-1:0] rs1_sel,
    input  logic [$clog2(registerQuantity)-1:0] rs2_sel,
    output logic                                fwd1_hit,
    output logic                                fwd2_hit,
    output logic [registerSize-1:0]             fwd1_data,
    output logic [registerSize-1:0]             fwd2_data,
`endif
    output logic                                regWrEn,
    output logic [$clog2(registerQuantity)-1:0] regToWrite,
    output logic [registerSize-1:0]             dataIn,
    output logic [registerQuantity-1:0]         pend_mask
);

    localparam int unsigned IDX_W = $clog2(registerQuantity);
    localparam int unsigned CNT_W = $clog2(2*FIFO_DEPTH+2);

    typedef struct packed {
        logic [IDX_W-1:0]        idx;
        logic [registerSize-1:0] data;
    } req_t;

    logic aluFull, aluEmpty, memFull, memEmpty;
    logic aluPush, memPush, aluPop, memPop;
    req_t aluHead, memHead, grantReq;
    logic grant;
    src_e grantSrc;
    src_e rrPtr;

    logic [CNT_W-1:0] pendCnt [registerQuantity];
    logic [CNT_W-1:0] cntNext [registerQuantity];
    logic [1:0]       incr    [registerQuantity];
    logic             decr    [registerQuantity];

    assign alu_ready = !aluFull;
    assign mem_ready = !memFull;
    assign aluPush   = alu_valid && !aluFull;
    assign memPush   = mem_valid && !memFull;

    scalar_wb_fifo #(.T(req_t), .DEPTH(FIFO_DEPTH)) aluFifo (
        .clk(clk), .reset(reset),
        .push(aluPush), .pushData(req_t'{idx: alu_idx, data: alu_data}),
        .pop(aluPop), .full(aluFull), .empty(aluEmpty), .head(aluHead)
    );

    scalar_wb_fifo #(.T(req_t), .DEPTH(FIFO_DEPTH)) memFifo (
        .clk(clk), .reset(reset),
        .push(memPush), .pushData(req_t'{idx: mem_idx, data: mem_data}),
        .pop(memPop), .full(memFull), .empty(memEmpty), .head(memHead)
    );

    // rrPtr names the source preferred when both heads are valid.
    always_comb begin
        grant    = 1'b0;
        grantSrc = SRC_ALU;
        if (!aluEmpty && !memEmpty) begin
            grant    = 1'b1;
            grantSrc = rrPtr;
        end else if (!aluEmpty) begin
            grant    = 1'b1;
            grantSrc = SRC_ALU;
        end else if (!memEmpty) begin
            grant    = 1'b1;
            grantSrc = SRC_MEM;
        end
        grantReq = (grantSrc == SRC_MEM) ? memHead : aluHead;
        aluPop   = grant && (grantSrc == SRC_ALU);
        memPop   = grant && (grantSrc == SRC_MEM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rrPtr      <= SRC_ALU;
            regWrEn    <= 1'b0;
            regToWrite <= '0;
            dataIn     <= '0;
        end else begin
            regWrEn <= grant;
            if (grant) begin
                rrPtr      <= otherSrc(grantSrc);
                regToWrite <= grantReq.idx;
                dataIn     <= grantReq.data;
            end
        end
    end

    // A write counts as pending from its accept edge through the edge after its regWrEn cycle.
    always_comb begin
        for (int unsigned i = 0; i < registerQuantity; i++) begin
            incr[i]      = 2'(aluPush && (alu_idx == IDX_W'(i))) + 2'(memPush && (mem_idx == IDX_W'(i)));
            decr[i]      = regWrEn && (regToWrite == IDX_W'(i));
            cntNext[i]   = pendCnt[i] + CNT_W'(incr[i]) - CNT_W'(decr[i]);
            pend_mask[i] = (pendCnt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < registerQuantity; i++) begin
            if (reset) pendCnt[i] <= '0;
            else       pendCnt[i] <= cntNext[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < registerQuantity; i++) begin
                assert ((32'(pendCnt[i]) + 32'(incr[i]) >= 32'(decr[i])) &&
                        (32'(pendCnt[i]) + 32'(incr[i]) - 32'(decr[i]) < (32'd1 << CNT_W)));
            end
        end
    end

`ifdef SCALAR_WB_BYPASS_EN
    always_comb begin
        fwd1_hit  = regWrEn && (regToWrite == rs1_sel);
        fwd2_hit  = regWrEn && (regToWrite == rs2_sel);
        fwd1_data = fwd1_hit ? dataIn : '0;
        fwd2_data = fwd2_hit ? dataIn : '0;
    end
`endif

endmodule

// File: tb/tb_scalar_writeback_unit.sv
// Randomised bench for scalar_writeback_unit against a queue-based transaction model.
module tb_scalar_writeback_unit;

    localparam int unsigned RS = 8;
    localparam int unsigned RQ = 8;
    localparam int unsigned FD = 4;
    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          alu_valid = 1'b0, mem_valid = 1'b0;
    logic          alu_ready, mem_ready;
    logic [IW-1:0] alu_idx = '0, mem_idx = '0;
    logic [RS-1:0] alu_data = '0, mem_data = '0;
    logic          regWrEn;
    logic [IW-1:0] regToWrite;
    logic [RS-1:0] dataIn;
    logic [RQ-1:0] pend_mask;
`ifdef SCALAR_WB_BYPASS_EN
    logic [IW-1:0] rs1_sel = '0, rs2_sel = '0;
    logic          fwd1_hit, fwd2_hit;
    logic [RS-1:0] fwd1_data, fwd2_data;
`endif

    scalar_writeback_unit #(
        .registerSize(RS), .registerQuantity(RQ), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_idx(alu_idx), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_idx(mem_idx), .mem_data(mem_data),
`ifdef SCALAR_WB_BYPASS_EN
        .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
        .regWrEn(regWrEn), .regToWrite(regToWrite), .dataIn(dataIn), .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Model: one queue per source plus the write currently on the output port.
    typedef struct packed {
        logic [IW-1:0] idx;
        logic [RS-1:0] data;
    } ent_t;

    ent_t          aluQ[$];
    ent_t          memQ[$];
    bit            mOutValid = 1'b0;
    logic [IW-1:0] mOutIdx = '0;
    logic [RS-1:0] mOutData = '0;
    bit            mPrefAlu = 1'b1;
    int            handshakes = 0;
    int            dutWrites = 0;

    function automatic logic [RQ-1:0] expPend();
        logic [RQ-1:0] m = '0;
        foreach (aluQ[j]) m[aluQ[j].idx] = 1'b1;
        foreach (memQ[j]) m[memQ[j].idx] = 1'b1;
        if (mOutValid) m[mOutIdx] = 1'b1;
        return m;
    endfunction

    task automatic modelEdge(input bit av, input logic [IW-1:0] ai, input logic [RS-1:0] ad,
                             input bit mv, input logic [IW-1:0] mi, input logic [RS-1:0] md,
                             input bit r);
        bit   aAcc, mAcc;
        ent_t e;
        if (r) begin
            aluQ.delete();
            memQ.delete();
            mOutValid = 1'b0;
            mOutIdx   = '0;
            mOutData  = '0;
            mPrefAlu  = 1'b1;
            return;
        end
        aAcc = av && (aluQ.size() < FD);
        mAcc = mv && (memQ.size() < FD);
        if (aluQ.size() > 0 && (memQ.size() == 0 || mPrefAlu)) begin
            e = aluQ.pop_front();
            mOutValid = 1'b1; mOutIdx = e.idx; mOutData = e.data; mPrefAlu = 1'b0;
        end else if (memQ.size() > 0) begin
            e = memQ.pop_front();
            mOutValid = 1'b1; mOutIdx = e.idx; mOutData = e.data; mPrefAlu = 1'b1;
        end else begin
            mOutValid = 1'b0;
        end
        if (aAcc) aluQ.push_back(ent_t'{idx: ai, data: ad});
        if (mAcc) memQ.push_back(ent_t'{idx: mi, data: md});
        handshakes += int'(aAcc) + int'(mAcc);
    endtask

    task automatic checkAll(input string pfx);
        checkEq({pfx, "_regWrEn"},    64'(regWrEn),    64'(mOutValid));
        checkEq({pfx, "_regToWrite"}, 64'(regToWrite), 64'(mOutIdx));
        checkEq({pfx, "_dataIn"},     64'(dataIn),     64'(mOutData));
        checkEq({pfx, "_alu_ready"},  64'(alu_ready),  64'(aluQ.size() < FD));
        checkEq({pfx, "_mem_ready"},  64'(mem_ready),  64'(memQ.size() < FD));
        checkEq({pfx, "_pend_mask"},  64'(pend_mask),  64'(expPend()));
        if (regWrEn === 1'b1) dutWrites++;
`ifdef SCALAR_WB_BYPASS_EN
        rs1_sel = IW'($urandom_range(0, RQ-1));
        rs2_sel = mOutIdx;
        #1;
        checkEq({pfx, "_fwd1_hit"},  64'(fwd1_hit),  64'(mOutValid && rs1_sel == mOutIdx));
        checkEq({pfx, "_fwd1_data"}, 64'(fwd1_data), (mOutValid && rs1_sel == mOutIdx) ? 64'(mOutData) : 64'd0);
        checkEq({pfx, "_fwd2_hit"},  64'(fwd2_hit),  64'(mOutValid));
        checkEq({pfx, "_fwd2_data"}, 64'(fwd2_data), mOutValid ? 64'(mOutData) : 64'd0);
`endif
    endtask

    // Called at a negedge: drive inputs, advance model over the next posedge, check at the next negedge.
    task automatic step(input bit av, input logic [IW-1:0] ai, input logic [RS-1:0] ad,
                        input bit mv, input logic [IW-1:0] mi, input logic [RS-1:0] md,
                        input bit r, input string pfx);
        alu_valid = av; alu_idx = ai; alu_data = ad;
        mem_valid = mv; mem_idx = mi; mem_data = md;
        reset = r;
        modelEdge(av, ai, ad, mv, mi, md, r);
        @(negedge clk);
        checkAll(pfx);
    endtask

    task automatic idle(input string pfx);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, pfx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        modelEdge(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        checkAll("reset");

        // single ALU write to r3
        step(1'b1, 3'd3, 8'h5A, 1'b0, '0, '0, 1'b0, "t1_accept");
        checkEq("t1_pend3_set", 64'(pend_mask[3]), 64'd1);
        idle("t1_issue");
        checkEq("t1_wr_idx", 64'(regToWrite), 64'd3);
        checkEq("t1_wr_data", 64'(dataIn), 64'h5A);
        idle("t1_retire");
        checkEq("t1_pend3_clr", 64'(pend_mask[3]), 64'd0);

        // contention: alternating grants, per-source order
        for (int i = 0; i < 10; i++)
            step(1'b1, 3'd1, 8'(i), 1'b1, 3'd2, 8'(8'h80 + i), 1'b0, "t2_both");
        repeat (10) idle("t2_drain");

        // flood both sources until full, then drain; writes must equal handshakes
        handshakes = 0;
        dutWrites  = 0;
        for (int i = 0; i < 12; i++)
            step(1'b1, 3'($urandom), 8'($urandom), 1'b1, 3'($urandom), 8'($urandom), 1'b0, "t3_flood");
        checkEq("t3_alu_full", 64'(alu_ready), 64'd0);
        for (int i = 0; i < 12; i++) idle("t3_drain");
        checkEq("t3_writes_eq_handshakes", 64'(dutWrites), 64'(handshakes));

        // both sources target r5 on the same edge
        step(1'b1, 3'd5, 8'h11, 1'b1, 3'd5, 8'h22, 1'b0, "t4_accept");
        idle("t4_first");
        checkEq("t4_pend5_after_first", 64'(pend_mask[5]), 64'd1);
        idle("t4_second");
        checkEq("t4_pend5_after_second_issue", 64'(pend_mask[5]), 64'd1);
        idle("t4_done");
        checkEq("t4_pend5_clr", 64'(pend_mask[5]), 64'd0);

        // reset with several entries buffered
        step(1'b1, 3'd1, 8'hA1, 1'b1, 3'd2, 8'hB2, 1'b0, "t5_fill");
        step(1'b1, 3'd6, 8'hA3, 1'b1, 3'd7, 8'hB4, 1'b0, "t5_fill");
        step(1'b1, 3'd4, 8'hC5, 1'b1, 3'd0, 8'hD6, 1'b1, "t5_reset");
        checkEq("t5_wren_off", 64'(regWrEn), 64'd0);
        checkEq("t5_pend_clr", 64'(pend_mask), 64'd0);
        checkEq("t5_readies", 64'({alu_ready, mem_ready}), 64'd3);
        for (int i = 0; i < 4; i++) idle("t5_quiet");

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) < 60), 3'($urandom), 8'($urandom),
                 1'($urandom_range(0, 99) < 55), 3'($urandom), 8'($urandom),
                 1'($urandom_range(0, 63) == 0), "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
